// File: rtl/clk_div_prog.sv
// Programmable clock-enable / square-wave divider with exact N-cycle period,
// pending-divisor staging applied only at a period boundary or phase restart.
module clk_div_prog #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50_000),
   parameter logic [WIDTH-1:0] MIN_DIV     = WIDTH'(2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             tick_o,
   output logic             clk_o,
   output logic [WIDTH-1:0] div_o,
   output logic             pend_o
);

   logic [WIDTH-1:0] cnt_q, cnt_nxt;
   logic [WIDTH-1:0] div_q, div_nxt;
   logic [WIDTH-1:0] pval_q, pval_nxt;
   logic             pend_q, pend_nxt;
   logic             tick_q, tick_nxt;
   logic             clk_q, clk_nxt;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] new_div;
   logic [WIDTH-1:0] half_nxt;
   logic             wrap;
   logic             apply_div;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         div_q  <= DEFAULT_DIV;
         pval_q <= '0;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         clk_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_nxt;
         div_q  <= div_nxt;
         pval_q <= pval_nxt;
         pend_q <= pend_nxt;
         tick_q <= tick_nxt;
         clk_q  <= clk_nxt;
      end
   end

   always_comb begin
      load_val  = (div_in < MIN_DIV) ? MIN_DIV : div_in;
      wrap      = en && (cnt_q == div_q - WIDTH'(1));
      // A same-cycle load supersedes whatever is already pending.
      new_div   = div_load ? load_val : pval_q;
      apply_div = (sync || wrap) && (pend_q || div_load);

      cnt_nxt   = cnt_q;
      div_nxt   = div_q;
      pval_nxt  = pval_q;
      pend_nxt  = pend_q;

      if (div_load) begin
         pval_nxt = load_val;
         pend_nxt = 1'b1;
      end
      if (apply_div) begin
         div_nxt  = new_div;
         pend_nxt = 1'b0;
      end

      if (sync || wrap)
         cnt_nxt = '0;
      else if (en)
         cnt_nxt = cnt_q + WIDTH'(1);

      // Outputs are decoded from the next state so they line up with cnt.
      half_nxt = div_nxt - (div_nxt >> 1);
      clk_nxt  = (cnt_nxt >= half_nxt);
      tick_nxt = (cnt_nxt == div_nxt - WIDTH'(1));
   end

   // tick is suppressed in any cycle the counter is frozen.
   assign tick_o = tick_q & en;
   assign clk_o  = clk_q;
   assign div_o  = div_q;
   assign pend_o = pend_q;

endmodule
